// File: rtl/deser_align_ctrl.sv
// rtl/deser_align_ctrl.sv - K28.5 word-alignment controller for the 8b10b SIPO receive path
// Tracks the 10-bit symbol boundary from comma hits and emits aligned symbols once locked.
module deser_align_ctrl #(
   parameter int LOCK_COMMAS = 3,
   parameter int LOSS_LIMIT  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_valid,
   output logic       sipo_en,
   input  logic [9:0] sipo_q,
   output logic [9:0] word_out,
   output logic       word_valid,
   output logic       word_is_comma,
   output logic       locked,
   output logic       realign
);
   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int MW = $clog2(LOSS_LIMIT + 1);
   localparam logic [CW-1:0] COMMA_LAST = CW'(LOCK_COMMAS - 1);
   localparam logic [CW-1:0] COMMA_FULL = CW'(LOCK_COMMAS);
   localparam logic [MW-1:0] MISS_LAST  = MW'(LOSS_LIMIT - 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t          state, state_n;
   logic            samp;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [CW-1:0]   comma_cnt, comma_cnt_n;
   logic [MW-1:0]   miss_cnt, miss_cnt_n;
   logic [9:0]      word_n;
   logic            word_valid_n, word_is_comma_n, realign_n;
   logic            comma, at_bnd, realign_hit, emit;

   assign sipo_en     = bit_valid;
   assign comma       = (sipo_q[9:3] == 7'b0011111) || (sipo_q[9:3] == 7'b1100000);
   assign at_bnd      = (bit_cnt == 4'd9);
   // In HUNT any comma defines the boundary; in SYNC an off-boundary comma restarts the count.
   assign realign_hit = comma && ((state == HUNT) || ((state == SYNC) && !at_bnd));

   always_comb begin
      state_n         = state;
      bit_cnt_n       = bit_cnt;
      comma_cnt_n     = comma_cnt;
      miss_cnt_n      = miss_cnt;
      word_n          = word_out;
      word_valid_n    = 1'b0;
      word_is_comma_n = word_is_comma;
      realign_n       = 1'b0;
      emit            = 1'b0;
      if (samp) begin
         bit_cnt_n = at_bnd ? 4'd0 : bit_cnt + 4'd1;
         if (realign_hit) begin
            bit_cnt_n   = 4'd0;
            comma_cnt_n = CW'(1);
            state_n     = SYNC;
            realign_n   = 1'b1;
         end else begin
            case (state)
               SYNC: begin
                  if (comma) begin
                     if (comma_cnt == COMMA_LAST) begin
                        state_n     = LOCKED;
                        comma_cnt_n = COMMA_FULL;
                        miss_cnt_n  = '0;
                        emit        = 1'b1;
                     end else begin
                        comma_cnt_n = comma_cnt + CW'(1);
                     end
                  end
               end
               LOCKED: begin
                  if (comma && !at_bnd) begin
                     if (miss_cnt == MISS_LAST) begin
                        state_n     = HUNT;
                        comma_cnt_n = '0;
                        miss_cnt_n  = '0;
                     end else begin
                        miss_cnt_n = miss_cnt + MW'(1);
                     end
                  end else if (at_bnd) begin
                     emit = 1'b1;
                     if (comma) miss_cnt_n = '0;
                  end
               end
               default: state_n = state;
            endcase
         end
      end
      if (emit) begin
         word_n          = sipo_q;
         word_valid_n    = 1'b1;
         word_is_comma_n = comma;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= HUNT;
         samp          <= 1'b0;
         bit_cnt       <= 4'd0;
         comma_cnt     <= '0;
         miss_cnt      <= '0;
         word_out      <= 10'd0;
         word_valid    <= 1'b0;
         word_is_comma <= 1'b0;
         locked        <= 1'b0;
         realign       <= 1'b0;
      end else begin
         state         <= state_n;
         samp          <= bit_valid;
         bit_cnt       <= bit_cnt_n;
         comma_cnt     <= comma_cnt_n;
         miss_cnt      <= miss_cnt_n;
         word_out      <= word_n;
         word_valid    <= word_valid_n;
         word_is_comma <= word_is_comma_n;
         locked        <= (state_n == LOCKED);
         realign       <= realign_n;
      end
   end
endmodule

// File: tb/tb_deser_align_ctrl.sv
// tb/tb_deser_align_ctrl.sv - directed self-checking bench for deser_align_ctrl
// Models the SIPO shift register and checks alignment, lock, loss of lock and word timing.
module tb_deser_align_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       bit_valid = 1'b0;
   logic       data_in = 1'b0;
   logic       sipo_en;
   logic [9:0] sipo_q;
   logic [9:0] word_out;
   logic       word_valid, word_is_comma, locked, realign;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int realign_cnt = 0;
   int gap = 0;
   int last_bit_cyc = 0;
   int r0;

   logic [9:0] wq[$];
   logic       wc[$];
   int         wt[$];
   int         lt[$];
   logic [9:0] data_seq [50];

   localparam logic [9:0] K_M   = 10'b0011111010;
   localparam logic [9:0] K_P   = 10'b1100000101;
   localparam logic [9:0] D21_5 = 10'b1010101010;
   localparam logic [9:0] D10_2 = 10'b0101010101;

   deser_align_ctrl #(.LOCK_COMMAS(3), .LOSS_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .sipo_en(sipo_en),
      .sipo_q(sipo_q), .word_out(word_out), .word_valid(word_valid),
      .word_is_comma(word_is_comma), .locked(locked), .realign(realign)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sipo_q <= '0;
      else if (sipo_en) sipo_q <= {sipo_q[8:0], data_in};
   end

   // Monitor samples 2 time units after each rising edge, away from the driving negedge.
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      if (word_valid) begin
         wq.push_back(word_out);
         wc.push_back(word_is_comma);
         wt.push_back(cyc);
      end
      if (realign) realign_cnt = realign_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit has_run5(input logic [13:0] w);
      for (int i = 0; i < 10; i++)
         if (w[i +: 5] == 5'b11111 || w[i +: 5] == 5'b00000) return 1'b1;
      return 1'b0;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_valid = 1'b1;
      data_in = b;
      last_bit_cyc = cyc;
      repeat (gap) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
   endtask

   task automatic send_sym(input logic [9:0] s);
      for (int i = 9; i >= 0; i--) send_bit(s[i]);
      lt.push_back(last_bit_cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
   endtask

   task automatic clear_q();
      wq.delete(); wc.delete(); wt.delete(); lt.delete();
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
      n_checks++; if (word_out !== 10'd0) begin n_fail++; $display("FAIL reset_word_out: got %h expected 000", word_out); end
      n_checks++; if (locked !== 1'b0 || realign !== 1'b0 || word_is_comma !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: got locked=%b realign=%b comma=%b expected 0", locked, realign, word_is_comma); end
      bit_valid = 1'b1;
      #1;
      n_checks++; if (sipo_en !== 1'b1) begin n_fail++; $display("FAIL reset_sipo_en: got %b expected 1", sipo_en); end
      @(negedge clk);
      bit_valid = 1'b0;
      reset = 1'b0;
      clear_q();
      r0 = realign_cnt;
      for (int i = 0; i < 10; i++) send_bit(1'b0);
      idle(3);
      n_checks++; if (realign_cnt !== r0) begin n_fail++; $display("FAIL reset_zeros_realign: got %0d expected %0d", realign_cnt, r0); end
      n_checks++; if (wq.size() !== 0) begin n_fail++; $display("FAIL reset_zeros_words: got %0d expected 0", wq.size()); end
   endtask

   task automatic test_acquire();
      clear_q();
      r0 = realign_cnt;
      gap = 0;
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      send_sym(K_M);
      idle(2);
      n_checks++; if (realign_cnt !== r0 + 1) begin n_fail++; $display("FAIL acq_first_realign: got %0d expected %0d", realign_cnt, r0 + 1); end
      send_sym(D21_5);
      send_sym(K_P);
      send_sym(D10_2);
      idle(2);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_locked_early: got %b expected 0", locked); end
      send_sym(K_M);
      idle(1);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_locked_n1: got %b expected 0", locked); end
      idle(1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL acq_locked_n2: got %b expected 1", locked); end
      n_checks++; if (wq.size() !== 1) begin n_fail++; $display("FAIL acq_word_count: got %0d expected 1", wq.size()); end
      else begin
         n_checks++; if (wq[0] !== K_M || wc[0] !== 1'b1) begin
            n_fail++; $display("FAIL acq_first_word: got %h/%b expected %h/1", wq[0], wc[0], K_M); end
      end
      n_checks++; if (realign_cnt !== r0 + 1) begin n_fail++; $display("FAIL acq_realign_total: got %0d expected %0d", realign_cnt, r0 + 1); end
   endtask

   task automatic test_continuous();
      logic [9:0] prev, s;
      prev = K_M;
      for (int i = 0; i < 50; i++) begin
         do s = 10'($urandom); while (has_run5({prev[3:0], s}));
         data_seq[i] = s;
         prev = s;
      end
      clear_q();
      gap = 0;
      for (int i = 0; i < 50; i++) send_sym(data_seq[i]);
      idle(4);
      n_checks++; if (wq.size() !== 50) begin n_fail++; $display("FAIL cont_count: got %0d expected 50", wq.size()); end
      for (int i = 0; i < 50 && i < wq.size(); i++) begin
         n_checks++; if (wq[i] !== data_seq[i] || wc[i] !== 1'b0) begin
            n_fail++; $display("FAIL cont_word[%0d]: got %h/%b expected %h/0", i, wq[i], wc[i], data_seq[i]); end
         n_checks++; if (wt[i] - lt[i] !== 2) begin
            n_fail++; $display("FAIL cont_latency[%0d]: got %0d expected 2", i, wt[i] - lt[i]); end
         if (i > 0) begin
            n_checks++; if (wt[i] - wt[i-1] !== 10) begin
               n_fail++; $display("FAIL cont_spacing[%0d]: got %0d expected 10", i, wt[i] - wt[i-1]); end
         end
      end
   endtask

   task automatic test_gappy();
      clear_q();
      gap = 2;
      send_sym(K_M);
      for (int i = 0; i < 50; i++) send_sym(data_seq[i]);
      gap = 0;
      idle(6);
      n_checks++; if (wq.size() !== 51) begin n_fail++; $display("FAIL gap_count: got %0d expected 51", wq.size()); end
      else begin
         n_checks++; if (wq[0] !== K_M || wc[0] !== 1'b1) begin
            n_fail++; $display("FAIL gap_comma: got %h/%b expected %h/1", wq[0], wc[0], K_M); end
         for (int i = 1; i < 51; i++) begin
            n_checks++; if (wq[i] !== data_seq[i-1]) begin
               n_fail++; $display("FAIL gap_word[%0d]: got %h expected %h", i, wq[i], data_seq[i-1]); end
            n_checks++; if (wt[i] - wt[i-1] !== 30 || wt[i] - lt[i] !== 2) begin
               n_fail++; $display("FAIL gap_timing[%0d]: got spacing %0d latency %0d expected 30 and 2", i, wt[i] - wt[i-1], wt[i] - lt[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      gap = 0;
      for (int i = 9; i >= 5; i--) send_bit(D21_5[i]);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (locked !== 1'b0 || word_valid !== 1'b0 || realign !== 1'b0 || word_out !== 10'd0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got locked=%b valid=%b realign=%b word=%h expected all 0", locked, word_valid, realign, word_out); end
      n_checks++; if (sipo_en !== 1'b1) begin n_fail++; $display("FAIL mid_reset_sipo_en: got %b expected 1", sipo_en); end
      @(negedge clk);
      bit_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      clear_q();
      r0 = realign_cnt;
      for (int i = 0; i < 10; i++) send_bit(1'b0);
      idle(3);
      n_checks++; if (realign_cnt !== r0 || wq.size() !== 0 || locked !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_after: got realigns=%0d words=%0d locked=%b expected 0 0 0", realign_cnt - r0, wq.size(), locked); end
   endtask

   task automatic test_slip_sync();
      r0 = realign_cnt;
      send_sym(K_M);
      send_sym(D21_5);
      send_bit(1'b0);
      send_sym(K_M);
      idle(2);
      n_checks++; if (realign_cnt !== r0 + 2) begin n_fail++; $display("FAIL slip_realign: got %0d expected %0d", realign_cnt - r0, 2); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL slip_locked0: got %b expected 0", locked); end
      send_sym(D10_2);
      send_sym(K_P);
      idle(2);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL slip_locked1: got %b expected 0", locked); end
      send_sym(D21_5);
      send_sym(K_M);
      idle(2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL slip_locked2: got %b expected 1", locked); end
   endtask

   task automatic test_loss_of_lock();
      r0 = realign_cnt;
      send_bit(1'b0);
      send_sym(K_M);
      send_sym(D21_5);
      send_sym(K_M);
      send_sym(D21_5);
      send_sym(K_M);
      idle(2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_after3: got %b expected 1", locked); end
      send_sym(D21_5);
      send_sym(K_M);
      idle(1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_n1: got %b expected 1", locked); end
      idle(1);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_n2: got %b expected 0", locked); end
      n_checks++; if (realign_cnt !== r0) begin n_fail++; $display("FAIL loss_no_realign: got %0d expected 0", realign_cnt - r0); end
      send_sym(D21_5);
      send_sym(K_M);
      idle(2);
      n_checks++; if (realign_cnt !== r0 + 1) begin n_fail++; $display("FAIL loss_next_realign: got %0d expected 1", realign_cnt - r0); end
   endtask

   task automatic test_recover();
      r0 = realign_cnt;
      send_sym(D21_5);
      send_sym(K_P);
      send_sym(D10_2);
      send_sym(K_M);
      idle(2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rec_relock: got %b expected 1", locked); end
      send_bit(1'b0);
      send_sym(K_M);
      send_sym(D21_5);
      send_sym(K_M);
      send_sym(D21_5);
      send_sym(K_M);
      send_sym(D21_5);
      for (int i = 0; i < 9; i++) send_bit(1'(i % 2));
      clear_q();
      send_sym(K_M);
      idle(2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rec_after_aligned: got %b expected 1", locked); end
      n_checks++; if (wq.size() < 1) begin n_fail++; $display("FAIL rec_word: got %0d words expected 1", wq.size()); end
      else if (wq[wq.size()-1] !== K_M || wc[wc.size()-1] !== 1'b1) begin
         n_fail++; $display("FAIL rec_word: got %h/%b expected %h/1", wq[wq.size()-1], wc[wc.size()-1], K_M); end
      send_bit(1'b0);
      send_sym(K_M);
      idle(2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rec_miss_cleared: got %b expected 1", locked); end
      n_checks++; if (realign_cnt !== r0) begin n_fail++; $display("FAIL rec_no_realign: got %0d expected 0", realign_cnt - r0); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_continuous();
      test_gappy();
      test_reset_mid();
      test_slip_sync();
      test_loss_of_lock();
      test_recover();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/deser_align_ctrl.md
# deser_align_ctrl

Word-alignment controller for the 8b10b receive path. Drives the enable of the team's 10-bit serial-in/parallel-out shift register (left shift, newest bit at LSB) and watches its parallel output for the K28.5 comma. Finds and tracks the 10-bit symbol boundary, then emits aligned symbols with a valid strobe to the 8b10b decoder. Lock is declared after repeated aligned commas and dropped after repeated misaligned ones.

## Interface
- LOCK_COMMAS, 3: aligned commas, counting the first, needed to move from SYNC to LOCKED (≥2).
- LOSS_LIMIT, 4: consecutive misaligned commas in LOCKED that force HUNT (≥1).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; shares reset with the SIPO.
- bit_valid  in  1  serial bit present on the SIPO data_in this cycle.
- sipo_en  out  1  SIPO enable; combinational, equals bit_valid.
- sipo_q  in  10  SIPO parallel output; [9] oldest bit (8b10b bit a), [0] newest (bit j).
- word_out  out  10  aligned symbol, {a,b,c,d,e,i,f,g,h,j}.
- word_valid  out  1  one-cycle strobe, word_out valid (LOCKED only).
- word_is_comma  out  1  qualifies word_out as a comma; meaningful with word_valid.
- locked  out  1  state == LOCKED.
- realign  out  1  one-cycle pulse whenever bit_cnt is forced to 0 by a comma off the current boundary.

## Operation
- samp: register of bit_valid; high in the cycle after a shift, when sipo_q holds the new bit. All evaluation happens only on samp.
- comma = (sipo_q[9:3] == 7'b0011111) || (sipo_q[9:3] == 7'b1100000). Both disparities. sipo_q reset value (zeros) never matches.
- bit_cnt (4 b, 0..9): at_bnd = (bit_cnt == 9). On samp: bit_cnt <= at_bnd ? 0 : bit_cnt+1, unless overridden below.
- comma_cnt: saturating at LOCK_COMMAS. miss_cnt: saturating at LOSS_LIMIT.
- State HUNT, or (SYNC and comma and !at_bnd): bit_cnt<=0, comma_cnt<=1, state<=SYNC, realign<=1. bit_cnt is ignored in HUNT.
- SYNC, comma and at_bnd: comma_cnt+1. Reaching LOCK_COMMAS: state<=LOCKED, miss_cnt<=0. Non-comma at boundary is normal data, no change.
- LOCKED, at_bnd: word_out<=sipo_q, word_valid<=1, word_is_comma<=comma. If comma: miss_cnt<=0.
- LOCKED, comma and !at_bnd: miss_cnt+1; boundary is not moved, no realign. Reaching LOSS_LIMIT: state<=HUNT, comma_cnt<=0, miss_cnt<=0. The same-sample boundary logic does not run.
- A non-comma at boundary does not touch miss_cnt.
- Next sample after the drop to HUNT: a comma there realigns immediately.
- Gaps in bit_valid: counters and state hold. No timeout.

## Timing
- Reset values: state HUNT, bit_cnt 0, comma_cnt 0, miss_cnt 0, samp 0, word_out 0, word_valid 0, word_is_comma 0, locked 0, realign 0. sipo_en follows bit_valid even during reset.
- Latency: bit_valid high in cycle N for the 10th bit of a symbol. SIPO updates at the end of N. samp high in N+1. word_valid/word_out/realign registered at the end of N+1, visible in N+2.
- bit_valid may be high every cycle. Throughput: one word per 10 bits.
- locked is registered. It rises in the cycle word_valid could first appear and falls the cycle after the LOSS_LIMIT-th misaligned comma is sampled.
- Reset mid-symbol: everything returns to reset values asynchronously. After release, realignment requires a new comma.

## Test plan
- Reset: assert mid-stream → all outputs 0, state HUNT. After release, feed 10 bits of 0x000 → no realign, no word_valid.
- Acquire: 3 random bits, then K28.5 RD- (0011111010), D21.5, K28.5 RD+ (1100000101), D10.2, K28.5 RD- → realign at the first comma. locked rises after the third comma. First word_valid is on that comma, with word_is_comma=1.
- Continuous data: 50 random data symbols while locked, bit_valid every cycle → word_valid every 10 cycles. word_out equals the sent symbol. Latency is exactly 2 cycles after the 10th bit.
- Gappy input: bit_valid 1-of-3 cycles → identical word sequence, with word_valid spaced 30 cycles.
- Slip in SYNC: after the first comma, insert 1 extra bit before the next comma → realign pulse, comma_cnt back to 1. Lock needs 2 further aligned commas.
- Loss of lock: while locked, slip by 1 bit and send 4 commas → locked falls after the 4th, no realign during LOCKED. The next comma realigns. With 3 misaligned then 1 aligned comma → stays locked, miss_cnt 0.
